// File: rtl/rotator_pkg.sv
// Shared encodings for the rotating-pattern lab blocks: mode constants and bounce direction.
package rotator_pkg;

    localparam logic [1:0] MODE_ROL    = 2'b00;
    localparam logic [1:0] MODE_ROR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/pattern_rotator_if.sv
// Control and pattern signals of pattern_rotator, grouped with driver (master) and rotator (slave) views.
interface pattern_rotator_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] d;
    logic             step;
    logic             wrap;

    modport master (
        output en, mode, div, load, load_data,
        input  d, step, wrap
    );

    modport slave (
        input  en, mode, div, load, load_data,
        output d, step, wrap
    );
endinterface

// File: rtl/rotator_prescaler.sv
// Enable-gated prescaler: asserts tick on every div+1-th enabled cycle; clr restarts the count.
module rotator_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Comparing with >= lets a div lowered below the running count fire on the next enabled cycle.
    assign tick = en && !clr && (cnt >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pattern_rotator.sv
// WIDTH-bit rotating/bouncing pattern register with prescaled stepping and step/wrap strobes.
// Bounce mode and its direction FSM exist only when PATTERN_ROTATOR_BOUNCE_EN is defined.
module pattern_rotator #(
    parameter int               WIDTH = 8,
    parameter int               DIV_W = 4,
    parameter logic [WIDTH-1:0] INIT  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic              clk,
    input  logic              rst_n,
    pattern_rotator_if.slave  bus
);
    import rotator_pkg::*;

    logic             tick;
    logic [WIDTH-1:0] d_q, d_next;
    logic             step_q, step_next;
    logic             wrap_q, wrap_next;
    logic [WIDTH-1:0] rol, ror, shl, shr;

`ifdef PATTERN_ROTATOR_BOUNCE_EN
    dir_t dir_q, dir_next;
`endif

    rotator_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .clr   (bus.load),
        .div   (bus.div),
        .tick  (tick)
    );

    assign rol = {d_q[WIDTH-2:0], d_q[WIDTH-1]};
    assign ror = {d_q[0], d_q[WIDTH-1:1]};
    assign shl = {d_q[WIDTH-2:0], 1'b0};
    assign shr = {1'b0, d_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= INIT;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
`ifdef PATTERN_ROTATOR_BOUNCE_EN
            dir_q  <= DIR_LEFT;
`endif
        end else begin
            d_q    <= d_next;
            step_q <= step_next;
            wrap_q <= wrap_next;
`ifdef PATTERN_ROTATOR_BOUNCE_EN
            dir_q  <= dir_next;
`endif
        end
    end

    // Load outranks a tick; the mode present at the tick edge picks the operation.
    always_comb begin
        d_next    = d_q;
        step_next = 1'b0;
        wrap_next = 1'b0;
`ifdef PATTERN_ROTATOR_BOUNCE_EN
        dir_next  = dir_q;
`endif
        if (bus.load) begin
            d_next   = bus.load_data;
`ifdef PATTERN_ROTATOR_BOUNCE_EN
            dir_next = DIR_LEFT;
`endif
        end else if (tick) begin
            case (bus.mode)
                MODE_ROL: begin
                    d_next    = rol;
                    step_next = 1'b1;
                    wrap_next = d_q[WIDTH-1];
                end
                MODE_ROR: begin
                    d_next    = ror;
                    step_next = 1'b1;
                    wrap_next = d_q[0];
                end
                MODE_BOUNCE: begin
                    step_next = 1'b1;
`ifdef PATTERN_ROTATOR_BOUNCE_EN
                    // Both ends set: nowhere to go, so only the direction flips.
                    if (d_q[WIDTH-1] && d_q[0]) begin
                        dir_next  = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
                        wrap_next = 1'b1;
                    end else if (dir_q == DIR_LEFT) begin
                        if (d_q[WIDTH-1]) begin
                            dir_next  = DIR_RIGHT;
                            d_next    = shr;
                            wrap_next = 1'b1;
                        end else begin
                            d_next = shl;
                        end
                    end else begin
                        if (d_q[0]) begin
                            dir_next  = DIR_LEFT;
                            d_next    = shl;
                            wrap_next = 1'b1;
                        end else begin
                            d_next = shr;
                        end
                    end
`else
                    d_next    = rol;
                    wrap_next = d_q[WIDTH-1];
`endif
                end
                default: begin
                    d_next = d_q;
                end
            endcase
        end
    end

    assign bus.d    = d_q;
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_pattern_rotator.sv
// Directed, table-driven bench for pattern_rotator (WIDTH=8, DIV_W=4, INIT=01).
module tb_pattern_rotator;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] div;
        logic       en;
        logic       load;
        logic [7:0] load_data;
        logic [7:0] exp_d;
        logic       exp_step;
        logic       exp_wrap;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    pattern_rotator_if #(.WIDTH(8), .DIV_W(4)) bus ();

    pattern_rotator #(.WIDTH(8), .DIV_W(4), .INIT(8'h01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic [1:0] m, input logic [3:0] dv, input logic e,
                           input logic ld, input logic [7:0] ldd,
                           input logic [7:0] ed, input logic es, input logic ew);
        vec_t v;
        v.mode = m;  v.div = dv;  v.en = e;  v.load = ld;  v.load_data = ldd;
        v.exp_d = ed; v.exp_step = es; v.exp_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic [1:0] m, input logic [3:0] dv, input logic e,
                                  input logic ld, input logic [7:0] ldd);
        bus.mode      = m;
        bus.div       = dv;
        bus.en        = e;
        bus.load      = ld;
        bus.load_data = ldd;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [7:0] ed, input logic es,
                                input logic ew);
        checks++;
        if (bus.d !== ed || bus.step !== es || bus.wrap !== ew) begin
            errors++;
            $display("[TB] FAIL %s: got d=%02h step=%b wrap=%b, expected d=%02h step=%b wrap=%b",
                     name, bus.d, bus.step, bus.wrap, ed, es, ew);
        end
    endtask

    initial begin
        logic [7:0] bounce_d[15];
        logic       bounce_w[15];
        logic [7:0] ends_d[2];
        logic       ends_w[2];

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        apply_stimulus(2'b00, 4'd0, 1'b1, 1'b0, 8'h00);
        cycle();
        cycle();
        check_output("reset", 8'h01, 1'b0, 1'b0);
        rst_n = 1'b1;

        // rotate-left, div=0: one step per edge, wrap only on 80->01
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h08, 1'b1, 1'b0);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0);
        // hold for 10 cycles, then rotate-left steps on the very next edge
        for (int i = 0; i < 10; i++)
            add_vec(2'b11, 4'd0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0);
        // rotate-right, div=2 after loading 81
        add_vec(2'b01, 4'd2, 1'b1, 1'b1, 8'h81, 8'h81, 1'b0, 1'b0);
        add_vec(2'b01, 4'd2, 1'b1, 1'b0, 8'h00, 8'h81, 1'b0, 1'b0);
        add_vec(2'b01, 4'd2, 1'b1, 1'b0, 8'h00, 8'h81, 1'b0, 1'b0);
        add_vec(2'b01, 4'd2, 1'b1, 1'b0, 8'h00, 8'hC0, 1'b1, 1'b1);
        add_vec(2'b01, 4'd2, 1'b1, 1'b0, 8'h00, 8'hC0, 1'b0, 1'b0);
        add_vec(2'b01, 4'd2, 1'b1, 1'b0, 8'h00, 8'hC0, 1'b0, 1'b0);
        add_vec(2'b01, 4'd2, 1'b1, 1'b0, 8'h00, 8'h60, 1'b1, 1'b0);
        // en low for 5 cycles mid-count with div=3
        add_vec(2'b00, 4'd3, 1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        add_vec(2'b00, 4'd3, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        add_vec(2'b00, 4'd3, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            add_vec(2'b00, 4'd3, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        add_vec(2'b00, 4'd3, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        add_vec(2'b00, 4'd3, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0);
        // load coincident with a due tick wins; then non-one-hot rotation and wrap
        add_vec(2'b00, 4'd0, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'hB4, 1'b1, 1'b0);
        add_vec(2'b00, 4'd0, 1'b1, 1'b0, 8'h00, 8'h69, 1'b1, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].mode, vecs[i].div, vecs[i].en, vecs[i].load, vecs[i].load_data);
            cycle();
            check_output($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_step, vecs[i].exp_wrap);
        end

`ifdef PATTERN_ROTATOR_BOUNCE_EN
        bounce_d = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        bounce_w = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        ends_d   = '{8'h81, 8'h81};
        ends_w   = '{1, 1};
`else
        bounce_d = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01,
                     8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        bounce_w = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        ends_d   = '{8'h03, 8'h06};
        ends_w   = '{1, 0};
`endif
        // bounce sweep from 01
        apply_stimulus(2'b10, 4'd0, 1'b1, 1'b1, 8'h01);
        cycle();
        check_output("bounce_load", 8'h01, 1'b0, 1'b0);
        bus.load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            check_output($sformatf("bounce%0d", i), bounce_d[i], 1'b1, bounce_w[i]);
        end

        // both ends set
        bus.load      = 1'b1;
        bus.load_data = 8'h81;
        cycle();
        check_output("ends_load", 8'h81, 1'b0, 1'b0);
        bus.load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_output($sformatf("ends%0d", i), ends_d[i], 1'b1, ends_w[i]);
        end

        // zero pattern keeps stepping with no wrap
        bus.load      = 1'b1;
        bus.load_data = 8'h00;
        cycle();
        bus.load = 1'b0;
        cycle();
        check_output("bounce_zero", 8'h00, 1'b1, 1'b0);

        // async reset between edges
        apply_stimulus(2'b11, 4'd0, 1'b1, 1'b1, 8'h5A);
        cycle();
        check_output("pre_reset", 8'h5A, 1'b0, 1'b0);
        bus.load = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async_reset", 8'h01, 1'b0, 1'b0);
        rst_n = 1'b1;

        // first step lands on the (div+1)-th edge after reset release
        apply_stimulus(2'b00, 4'd2, 1'b1, 1'b0, 8'h00);
        cycle();
        check_output("post_reset0", 8'h01, 1'b0, 1'b0);
        cycle();
        check_output("post_reset1", 8'h01, 1'b0, 1'b0);
        cycle();
        check_output("post_reset2", 8'h02, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_rotator.md
# pattern_rotator

Parametrised successor to the team's fixed 8-bit rotating register, used to drive LED bars and one-hot sequencers in the state-machine labs. Holds a WIDTH-bit pattern and advances it once per programmable number of enabled clocks. Modes are rotate-left, rotate-right, bounce (ping-pong shift with direction FSM) and hold. The pattern is synchronously loadable, and the block emits step and wrap strobes for downstream counters.

## Interface
- WIDTH, default 8: pattern width, ≥2.
- DIV_W, default 4: width of the prescale divider.
- INIT, default {{(WIDTH-1){1'b0}},1'b1}: pattern value after reset.
- clk  in  1: rising-edge clock.
- rst_n  in  1: reset, asynchronous, active-low.
- en  in  1: count enable for the prescaler; when low, the pattern, counter and FSM hold.
- mode  in  2: 00 rotate-left, 01 rotate-right, 10 bounce, 11 hold.
- div  in  DIV_W: the pattern steps once every div+1 enabled cycles.
- load  in  1: synchronous load of load_data.
- load_data  in  WIDTH: value written on load.
- d  out  WIDTH: current pattern (registered).
- step  out  1: one-cycle strobe, high in the cycle d shows a newly stepped value.
- wrap  out  1: one-cycle strobe coincident with step, marking a wrap or reversal.

## Operation
- Reset (async, rst_n=0):
  - d=INIT, cnt=0, dir=LEFT, step=0, wrap=0.
- Priority per clock: load > en.
- Load:
  - d=load_data, cnt=0, dir=LEFT, step=0, wrap=0.
  - A load applies regardless of en and mode.
- Prescaler, when en=1:
  - If cnt>=div: tick, and cnt←0.
  - Otherwise cnt←cnt+1.
  - Using >= means a div reduced mid-count ticks on the next enabled cycle.
  - div=0 ticks every enabled cycle, which is the legacy behaviour.
- On tick, by mode:
  - 00 rotate-left: d←{d[WIDTH-2:0],d[WIDTH-1]}. wrap=1 when the old d[WIDTH-1]=1.
  - 01 rotate-right: d←{d[0],d[WIDTH-1:1]}. wrap=1 when the old d[0]=1.
  - 10 bounce, FSM states LEFT and RIGHT:
    - LEFT with d[WIDTH-1]=0: shift left, zero fill.
    - LEFT with d[WIDTH-1]=1: dir←RIGHT, shift right this tick, wrap=1.
    - RIGHT with d[0]=0: shift right.
    - RIGHT with d[0]=1: dir←LEFT, shift left, wrap=1.
    - If both ends are 1 (e.g. all-ones), the pattern does not move, dir toggles and wrap=1.
    - A zero pattern stays zero, with step=1 and wrap=0.
  - 11 hold: d is unchanged and step=0, but the prescaler keeps counting.
- dir persists across mode changes and is only used in bounce.
- A mode change takes effect on the next tick; cnt is not cleared.
- No tick: step=0 and wrap=0.

## Timing
- d, step and wrap are all registered.
- With en held high, the first step occurs at the (div+1)-th rising edge after reset release or load.
- Zero-latency response to mode: the mode sampled at the tick edge selects the operation.
- rst_n assertion mid-operation clears everything immediately, without waiting for clk.
- Deassertion is synchronised externally and is not this block's concern.

## Configuration
- PATTERN_ROTATOR_BOUNCE_EN defined: bounce mode and the dir FSM are present as described.
- Undefined: no dir register is built; mode 10 behaves exactly as 00 (rotate-left, same wrap rule).

## Structure
- The shared package rotator_pkg holds:
  - the mode encoding constants MODE_ROL, MODE_ROR, MODE_BOUNCE, MODE_HOLD;
  - the dir_t enum {DIR_LEFT, DIR_RIGHT}.
- One sub-module, rotator_prescaler (DIV_W parameter; inputs en, clr, div; output tick), reused by other timed lab blocks.
- Pattern datapath and FSM stay in pattern_rotator.

## Test plan
- Reset, then mode=00, div=0, en=1 with WIDTH=8: d goes 01→02→04…→80→01. wrap=1 only on the 80→01 step.
- mode=01, div=2, load_data=8'h81 loaded: one step every 3 cycles, 81→C0→60. wrap=1 on the first step only.
- mode=10 from 01: d goes 01,02,…,80 then 40 (wrap=1, dir=RIGHT) …01 then 02 (wrap=1). The same run with the macro undefined rotates left.
- en toggled low for 5 cycles mid-count with div=3: cnt and d hold, and the step occurs after the remaining enabled cycles.
- load asserted together with a tick: d=load_data, step=0, cnt=0. rst_n pulsed low between edges: d=01 immediately.
- mode=11 with div=0: d unchanged and step=0 for 10 cycles. Switching to 00 steps on the very next edge.
